bit_width_restore: RTL and testbench
====================================

# bit_width_restore

Streaming inverse of the team's narrowing cast. Accepts narrow signed samples, each produced by dropping the LSBs of a wide sample with an arithmetic right shift, and rebuilds WIDE_WIDTH signed samples by shifting the data back up. A half-LSB offset can be inserted into the restored low bits for bias-free reconstruction. Sits on the receive side of a reduced-width link, between the link deserialiser and full-precision DSP. Carries valid/ready handshakes on both sides, with a 2-entry skid buffer and a sample counter.

## Interface
Parameters:
- NARROW_WIDTH, 16, input sample width; must be ≥ 1 and ≤ WIDE_WIDTH.
- WIDE_WIDTH, 32, output sample width.
- ROUND_HALF, 1, when 1 and SHIFT > 0, the restored low bits are set to the midpoint 1<<(SHIFT-1); when 0 they are zero.
- Derived: SHIFT = WIDE_WIDTH − NARROW_WIDTH.

Ports (reset is asynchronous, active-low):
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept; registered.
- in_data  in  NARROW_WIDTH  signed narrow sample.
- in_last  in  1  frame-end marker, travels with its sample.
- out_valid  out  1  restored sample present.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDE_WIDTH  signed restored sample.
- out_last  out  1  frame-end marker of the sample on out_data.
- cnt_clear  in  1  synchronous clear of sample_count.
- sample_count  out  32  number of output transfers, saturating.

## Operation
- Restore rule:
  - out value = {in_data, LOW}, where LOW is SHIFT bits, equal to 1<<(SHIFT-1) if ROUND_HALF else 0.
  - SHIFT = 0 is a pure pass-through; ROUND_HALF is ignored.
  - No saturation is needed; the result always fits.
  - Conversion is applied on push, so the buffer stores WIDE_WIDTH+1 bits per entry (data plus last).
- Skid buffer: two entries, FIFO order. Occupancy states:
  - EMPTY: out_valid=0, in_ready=1. Push → ONE.
  - ONE: out_valid=1, in_ready=1. Push without pop → FULL. Pop without push → EMPTY. Push with pop → ONE, new entry becomes head next cycle.
  - FULL: out_valid=1, in_ready=0. Pop → ONE. No push is possible.
- Transfer definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- in_valid while in_ready=0 is ignored. Upstream holds its data (AXI-stream rules).
- out_data and out_last must not change while out_valid=1 and out_ready=0.
- sample_count:
  - Increments by 1 on each pop.
  - Saturates at 32'hFFFF_FFFF.
  - cnt_clear has priority: count becomes 0 even if a pop occurs in the same cycle.
- Reset (asynchronous assert, synchronous deassert handled externally):
  - State → EMPTY; in_ready=1, out_valid=0, out_data=0, out_last=0, sample_count=0.
  - Reset mid-transfer discards buffered samples; no partial output appears afterwards.

## Timing
- Latency: a sample pushed at edge k is on out_data with out_valid=1 after edge k, i.e. one cycle.
- Throughput: one sample per cycle sustained while out_ready=1.
- in_ready is a register output with no combinational path from out_ready. It drops the cycle after the buffer reaches FULL and rises the cycle after the first pop from FULL.
- out_valid, out_data and out_last are register outputs.
- sample_count updates on the edge of the pop; it is visible the following cycle.

## Test plan
- Restore with ROUND_HALF=1 (16→32): in_data 16'h8000 → out_data 32'h8000_8000; 16'h7FFF → 32'h7FFF_8000; 16'h0000 → 32'h0000_8000.
- Restore with ROUND_HALF=0: 16'hFFFF → 32'hFFFF_0000. Pass-through build (16→16): 16'h1234 → 16'h1234.
- Backpressure with out_ready=0: push A, B, C on consecutive cycles → A and B accepted, in_ready low after B, C held. Raise out_ready → A, B, C appear in order, each value stable while stalled, and in_last tracks its sample.
- Streaming with out_ready=1: 100 back-to-back samples → 100 outputs with no bubbles after the first, and sample_count=100.
- Counter: preload to 32'hFFFF_FFFE, make 3 pops → holds at 32'hFFFF_FFFF. Assert cnt_clear with a simultaneous pop → 0.
- Reset mid-operation: assert rst_n low while FULL → out_valid=0, in_ready=1, sample_count=0 immediately (asynchronous). After release, the first output equals the first new input.

Source files
------------

// File: rtl/bit_width_restore.sv
// Restores narrow signed samples to WIDE_WIDTH by shifting back up, with an
// optional half-LSB fill, behind a 2-entry skid buffer and a saturating transfer counter.
module bit_width_restore #(
    parameter int NARROW_WIDTH = 16,
    parameter int WIDE_WIDTH   = 32,
    parameter int ROUND_HALF   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NARROW_WIDTH-1:0] in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDE_WIDTH-1:0]   out_data,
    output logic                    out_last,
    input  logic                    cnt_clear,
    output logic [31:0]             sample_count
);

    localparam int SHIFT   = WIDE_WIDTH - NARROW_WIDTH;
    localparam int LOW_POS = (SHIFT > 0) ? (SHIFT - 1) : 0;
    localparam int EW      = WIDE_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic            in_ready_r, in_ready_s;
    logic            out_valid_r, out_valid_s;
    logic [EW-1:0]   head_r, head_s;
    logic [EW-1:0]   skid_r, skid_s;
    logic [31:0]     cnt_r, cnt_s;
    logic            push_s, pop_s;
    logic [EW-1:0]   conv_s;

    // Buffer entry {last, restored data}; the upper NARROW_WIDTH bits carry the sample.
    function automatic logic [EW-1:0] restore(input logic [NARROW_WIDTH-1:0] d,
                                              input logic l);
        logic [WIDE_WIDTH-1:0] r;
        r = WIDE_WIDTH'(d) << SHIFT;
        if ((ROUND_HALF != 0) && (SHIFT > 0)) begin
            r = r | (WIDE_WIDTH'(1'b1) << LOW_POS);
        end else begin
            r = r;
        end
        return {l, r};
    endfunction

    assign push_s = in_valid & in_ready_r;
    assign pop_s  = out_valid_r & out_ready;
    assign conv_s = restore(in_data, in_last);

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next occupancy from push/pop.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) state_s = ST_ONE;
                else        state_s = ST_EMPTY;
            end
            ST_ONE: begin
                if (push_s && !pop_s)      state_s = ST_FULL;
                else if (!push_s && pop_s) state_s = ST_EMPTY;
                else                       state_s = ST_ONE;
            end
            ST_FULL: begin
                if (pop_s) state_s = ST_ONE;
                else       state_s = ST_FULL;
            end
            default: state_s = ST_EMPTY;
        endcase
    end

    // Handshake flags for the coming cycle, decoded from next state so they can be registered.
    always_comb begin
        in_ready_s  = 1'b1;
        out_valid_s = 1'b0;
        case (state_s)
            ST_EMPTY: begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
            ST_ONE:   begin in_ready_s = 1'b1; out_valid_s = 1'b1; end
            ST_FULL:  begin in_ready_s = 1'b0; out_valid_s = 1'b1; end
            default:  begin in_ready_s = 1'b1; out_valid_s = 1'b0; end
        endcase
    end

    // Head holds the presented sample; skid catches the one arriving while head stalls.
    always_comb begin
        head_s = head_r;
        skid_s = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) head_s = conv_s;
                else        head_s = head_r;
            end
            ST_ONE: begin
                if (push_s && pop_s) head_s = conv_s;
                else if (push_s)     skid_s = conv_s;
                else                 head_s = head_r;
            end
            ST_FULL: begin
                if (pop_s) head_s = skid_r;
                else       head_s = head_r;
            end
            default: begin
                head_s = head_r;
                skid_s = skid_r;
            end
        endcase
    end

    // Saturating transfer count; clear wins over a simultaneous pop.
    always_comb begin
        cnt_s = cnt_r;
        if (cnt_clear) begin
            cnt_s = 32'd0;
        end else if (pop_s && (cnt_r != 32'hFFFF_FFFF)) begin
            cnt_s = cnt_r + 32'd1;
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            head_r      <= '0;
            skid_r      <= '0;
            cnt_r       <= 32'd0;
        end else begin
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            head_r      <= head_s;
            skid_r      <= skid_s;
            cnt_r       <= cnt_s;
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_data     = head_r[WIDE_WIDTH-1:0];
    assign out_last     = head_r[WIDE_WIDTH];
    assign sample_count = cnt_r;

endmodule

// File: tb/tb_bit_width_restore.sv
// Bench for bit_width_restore: queue-based reference model with directed and random steps,
// plus two extra builds (no half-LSB fill, pass-through).
module tb_bit_width_restore;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_last, out_ready, cnt_clear;
    logic [15:0] in_data;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_data, sample_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_last;
    logic [15:0] b_in_data;
    logic [31:0] b_out_data, b_cnt;
    logic        c_in_ready, c_out_valid, c_out_last;
    logic [15:0] c_out_data;
    logic [31:0] c_cnt;

    int passed = 0;
    int total  = 0;

    logic [32:0] q[$];
    logic [31:0] mcnt;

    always #5 clk = ~clk;

    bit_width_restore #(.NARROW_WIDTH(16), .WIDE_WIDTH(32), .ROUND_HALF(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .cnt_clear(cnt_clear), .sample_count(sample_count));

    bit_width_restore #(.NARROW_WIDTH(16), .WIDE_WIDTH(32), .ROUND_HALF(0)) dut_rh0 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_last(1'b0), .out_valid(b_out_valid),
        .out_ready(1'b1), .out_data(b_out_data), .out_last(b_out_last),
        .cnt_clear(1'b0), .sample_count(b_cnt));

    bit_width_restore #(.NARROW_WIDTH(16), .WIDE_WIDTH(16), .ROUND_HALF(1)) dut_pt (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(c_in_ready),
        .in_data(b_in_data), .in_last(1'b1), .out_valid(c_out_valid),
        .out_ready(1'b1), .out_data(c_out_data), .out_last(c_out_last),
        .cnt_clear(1'b0), .sample_count(c_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Restored value with half-LSB fill, from plain arithmetic.
    function automatic logic [31:0] ref_restore(input logic [15:0] d);
        return 32'(d) * 32'd65536 + 32'd32768;
    endfunction

    task automatic check_main();
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("sample_count", 64'(sample_count), 64'(mcnt));
        if (q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(q[0][31:0]));
            chk("out_last", 64'(out_last), 64'(q[0][32]));
        end else begin
            total = total;
        end
    endtask

    // Called at a negedge: check, drive, advance one clock, update model.
    task automatic step(input logic v, input logic [15:0] d, input logic l,
                        input logic r, input logic clr);
        bit push, pop;
        check_main();
        in_valid = v; in_data = d; in_last = l; out_ready = r; cnt_clear = clr;
        push = v && (q.size() < 2);
        pop  = r && (q.size() > 0);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) q.push_back({l, ref_restore(d)});
        if (clr) mcnt = 32'd0;
        else if (pop && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
        b_in_valid = 1'b0; b_in_data = 16'h0;
        mcnt = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_count", 64'(sample_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed restore values with half-LSB fill.
        step(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        chk("r8000", 64'(out_data), 64'h8000_8000);
        step(1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        chk("r7FFF", 64'(out_data), 64'h7FFF_8000);
        step(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("r0000", 64'(out_data), 64'h0000_8000);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Other builds: no fill and pass-through.
        b_in_valid = 1'b1; b_in_data = 16'hFFFF;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("rh0_valid", 64'(b_out_valid), 64'd1);
        chk("rh0_FFFF", 64'(b_out_data), 64'hFFFF_0000);
        b_in_valid = 1'b1; b_in_data = 16'h1234;
        @(negedge clk);
        b_in_valid = 1'b0;
        chk("pt_1234", 64'(c_out_data), 64'h1234);
        chk("pt_last", 64'(c_out_last), 64'd1);

        // Backpressure: A, B accepted, C held until out_ready rises.
        step(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hBBBB, 1'b1, 1'b0, 1'b0);
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        step(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'hCCCC, 1'b1, 1'b0, 1'b0);
        chk("bp_head_A", 64'(out_data), 64'hAAAA_8000);
        step(1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b0);
        chk("bp_head_B", 64'(out_data), 64'hBBBB_8000);
        step(1'b1, 16'hCCCC, 1'b1, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Streaming 100 back-to-back samples from a cleared counter.
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, 16'($urandom), 1'($urandom), 1'b1, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("stream_count", 64'(sample_count), 64'd100);

        // Counter saturation from a preloaded value, then clear against a pop.
        step(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0);
        force dut.cnt_r = 32'hFFFF_FFFE;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        release dut.cnt_r;
        mcnt = 32'hFFFF_FFFE;
        step(1'b1, 16'h3333, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h4444, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
        chk("sat_count", 64'(sample_count), 64'hFFFF_FFFF);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        chk("clr_pop_count", 64'(sample_count), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++)
            step(1'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom_range(3, 0) != 0), ($urandom_range(40, 0) == 0));

        // Reset while FULL.
        step(1'b1, 16'h6666, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        chk("async_count", 64'(sample_count), 64'd0);
        q.delete();
        mcnt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, 16'h9ABC, 1'b1, 1'b0, 1'b0);
        chk("post_rst_head", 64'(out_data), 64'h9ABC_8000);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check_main();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
